// File: rtl/wb_stage_if.sv
// Writeback bus: per-slot results and issue-side busy marks in, register-file write ports out.
// Slot naming follows the execution units feeding the stage: LSU, IXU1, IXU2, BRANCH.
interface wb_stage_if #(
   parameter int DATA_W = 32
);
   logic              lsu_res_valid;
   logic [4:0]        lsu_res_rd;
   logic [DATA_W-1:0] lsu_res_data;
   logic              ixu1_res_valid;
   logic [4:0]        ixu1_res_rd;
   logic [DATA_W-1:0] ixu1_res_data;
   logic              ixu2_res_valid;
   logic [4:0]        ixu2_res_rd;
   logic [DATA_W-1:0] ixu2_res_data;
   logic              branch_res_valid;
   logic [4:0]        branch_res_rd;
   logic [DATA_W-1:0] branch_res_data;

   logic              lsu_set_en;
   logic [4:0]        lsu_set_rd;
   logic              ixu1_set_en;
   logic [4:0]        ixu1_set_rd;
   logic              ixu2_set_en;
   logic [4:0]        ixu2_set_rd;
   logic              branch_set_en;
   logic [4:0]        branch_set_rd;

   logic              lsu_wr_en;
   logic [4:0]        lsu_rd;
   logic [DATA_W-1:0] lsu_wr_data;
   logic              ixu1_wr_en;
   logic [4:0]        ixu1_rd;
   logic [DATA_W-1:0] ixu1_wr_data;
   logic              ixu2_wr_en;
   logic [4:0]        ixu2_rd;
   logic [DATA_W-1:0] ixu2_wr_data;
   logic              branch_wr_en;
   logic [4:0]        branch_rd;
   logic [DATA_W-1:0] branch_wr_data;

   // Master is the pipeline/issue side; slave is the writeback stage itself.
   modport master (
      output lsu_res_valid, lsu_res_rd, lsu_res_data,
      output ixu1_res_valid, ixu1_res_rd, ixu1_res_data,
      output ixu2_res_valid, ixu2_res_rd, ixu2_res_data,
      output branch_res_valid, branch_res_rd, branch_res_data,
      output lsu_set_en, lsu_set_rd, ixu1_set_en, ixu1_set_rd,
      output ixu2_set_en, ixu2_set_rd, branch_set_en, branch_set_rd,
      input  lsu_wr_en, lsu_rd, lsu_wr_data,
      input  ixu1_wr_en, ixu1_rd, ixu1_wr_data,
      input  ixu2_wr_en, ixu2_rd, ixu2_wr_data,
      input  branch_wr_en, branch_rd, branch_wr_data
   );

   modport slave (
      input  lsu_res_valid, lsu_res_rd, lsu_res_data,
      input  ixu1_res_valid, ixu1_res_rd, ixu1_res_data,
      input  ixu2_res_valid, ixu2_res_rd, ixu2_res_data,
      input  branch_res_valid, branch_res_rd, branch_res_data,
      input  lsu_set_en, lsu_set_rd, ixu1_set_en, ixu1_set_rd,
      input  ixu2_set_en, ixu2_set_rd, branch_set_en, branch_set_rd,
      output lsu_wr_en, lsu_rd, lsu_wr_data,
      output ixu1_wr_en, ixu1_rd, ixu1_wr_data,
      output ixu2_wr_en, ixu2_rd, ixu2_wr_data,
      output branch_wr_en, branch_rd, branch_wr_data
   );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: registers per-slot results for the register file, drops x0 writes,
// resolves same-destination conflicts by fixed priority and tracks a per-register busy scoreboard.
module wb_stage #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   wb_stage_if.slave           bus,
   input  logic                clear_stats,
   output logic [NUM_REGS-1:0] busy_mask,
   output logic                conflict_sticky,
   output logic [CNT_W-1:0]    conflict_cnt
);
   localparam int RW        = 5;
   localparam int NUM_SLOTS = 4;

   // Slot index doubles as priority: 0=LSU (lowest) .. 3=BRANCH (highest).
   logic [NUM_SLOTS-1:0] res_valid;
   logic [RW-1:0]        res_rd   [NUM_SLOTS];
   logic [DATA_W-1:0]    res_data [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] set_en;
   logic [RW-1:0]        set_rd   [NUM_SLOTS];

   logic [NUM_SLOTS-1:0] eligible;
   logic [NUM_SLOTS-1:0] win;
   logic                 conflict;
   logic [NUM_REGS-1:0]  busy_next;

   logic [NUM_SLOTS-1:0] wr_en_q;
   logic [RW-1:0]        rd_q     [NUM_SLOTS];
   logic [DATA_W-1:0]    data_q   [NUM_SLOTS];

   assign res_valid[0] = bus.lsu_res_valid;
   assign res_valid[1] = bus.ixu1_res_valid;
   assign res_valid[2] = bus.ixu2_res_valid;
   assign res_valid[3] = bus.branch_res_valid;
   assign res_rd[0]    = bus.lsu_res_rd;
   assign res_rd[1]    = bus.ixu1_res_rd;
   assign res_rd[2]    = bus.ixu2_res_rd;
   assign res_rd[3]    = bus.branch_res_rd;
   assign res_data[0]  = bus.lsu_res_data;
   assign res_data[1]  = bus.ixu1_res_data;
   assign res_data[2]  = bus.ixu2_res_data;
   assign res_data[3]  = bus.branch_res_data;

   assign set_en[0]    = bus.lsu_set_en;
   assign set_en[1]    = bus.ixu1_set_en;
   assign set_en[2]    = bus.ixu2_set_en;
   assign set_en[3]    = bus.branch_set_en;
   assign set_rd[0]    = bus.lsu_set_rd;
   assign set_rd[1]    = bus.ixu1_set_rd;
   assign set_rd[2]    = bus.ixu2_set_rd;
   assign set_rd[3]    = bus.branch_set_rd;

   assign bus.lsu_wr_en      = wr_en_q[0];
   assign bus.ixu1_wr_en     = wr_en_q[1];
   assign bus.ixu2_wr_en     = wr_en_q[2];
   assign bus.branch_wr_en   = wr_en_q[3];
   assign bus.lsu_rd         = rd_q[0];
   assign bus.ixu1_rd        = rd_q[1];
   assign bus.ixu2_rd        = rd_q[2];
   assign bus.branch_rd      = rd_q[3];
   assign bus.lsu_wr_data    = data_q[0];
   assign bus.ixu1_wr_data   = data_q[1];
   assign bus.ixu2_wr_data   = data_q[2];
   assign bus.branch_wr_data = data_q[3];

   // A slot keeps its write only if no higher-priority eligible slot targets the same register.
   always_comb begin
      eligible = '0;
      win      = '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
         eligible[s] = res_valid[s] && (res_rd[s] != '0);
      end
      for (int s = 0; s < NUM_SLOTS; s++) begin
         win[s] = eligible[s];
         for (int h = s + 1; h < NUM_SLOTS; h++) begin
            if (eligible[h] && (res_rd[h] == res_rd[s])) begin
               win[s] = 1'b0;
            end
         end
      end
      conflict = |(eligible & ~win);
   end

   // Clears are applied before sets so a freshly issued producer keeps its register busy.
   always_comb begin
      busy_next = busy_mask;
      for (int r = 1; r < NUM_REGS; r++) begin
         for (int s = 0; s < NUM_SLOTS; s++) begin
            if (res_valid[s] && (res_rd[s] == RW'(r))) begin
               busy_next[r] = 1'b0;
            end
         end
         for (int s = 0; s < NUM_SLOTS; s++) begin
            if (set_en[s] && (set_rd[s] == RW'(r))) begin
               busy_next[r] = 1'b1;
            end
         end
      end
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_en_q <= '0;
         for (int s = 0; s < NUM_SLOTS; s++) begin
            rd_q[s]   <= '0;
            data_q[s] <= '0;
         end
      end else begin
         wr_en_q <= win;
         for (int s = 0; s < NUM_SLOTS; s++) begin
            rd_q[s]   <= res_rd[s];
            data_q[s] <= res_data[s];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_mask <= '0;
      end else begin
         busy_mask <= busy_next;
      end
   end

   // Counts conflict cycles, not conflicting pairs; a clear in the same cycle takes precedence.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         conflict_sticky <= 1'b0;
         conflict_cnt    <= '0;
      end else if (clear_stats) begin
         conflict_sticky <= 1'b0;
         conflict_cnt    <= '0;
      end else if (conflict) begin
         conflict_sticky <= 1'b1;
         if (conflict_cnt != '1) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
         end
      end
   end
endmodule
